// File: rtl/audio_loader_pkg.sv
// Shared types and helpers for the UART sample loader.
// - rx_state_t   : serial receiver states
// - ld_state_t   : loader states
// - clks_per_bit : clock cycles per UART bit for a given clock and baud rate
package audio_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_WAIT,
        L_LOAD,
        L_DONE
    } ld_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sample_loader_if.sv
// Byte-wide write port toward the data memory (port A).
// - mem_addr  : byte address
// - mem_wdata : sample byte
// - mem_we    : single-cycle write strobe
// The loader drives the master modport; the memory side uses the slave modport.
interface uart_sample_loader_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        input mem_addr,
        input mem_wdata,
        input mem_we
    );
endinterface

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser plus 8N1 receive FSM.
// Ports:
// - clk_i, reset_i : clock, synchronous active-high reset
// - rx_i           : asynchronous serial input, idle high
// - rx_valid_o     : 1-cycle pulse, rx_byte_o holds a good byte
// - rx_byte_o      : received byte (LSB first on the wire)
// - stop_err_o     : 1-cycle pulse, stop bit sampled low (byte dropped)
module uart_rx_byte
    import audio_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       stop_err_o
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta_q;
    logic              rx_sync_q;
    rx_state_t         state_q;
    logic [TimerW-1:0] timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              rx_valid_q;
    logic              stop_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Preset high so reset never looks like a start bit.
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= RX_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_valid_q <= 1'b0;
            stop_err_q <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    timer_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit; a high line here was a glitch.
                    if (timer_q == HalfLast) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer_q == BitLast) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer_q == BitLast) begin
                        timer_q    <= '0;
                        rx_valid_q <= rx_sync_q;
                        stop_err_q <= !rx_sync_q;
                        state_q    <= RX_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_byte_o  = shift_q;
    assign stop_err_o = stop_err_q;

endmodule

// File: rtl/uart_sample_loader.sv
// Loads NUM_SAMPLES UART bytes into data memory port A and holds the
// processor in reset until the load is complete.
// Ports:
// - clk_i, reset_i : clock, synchronous active-high reset
// - uart_rx_i      : asynchronous serial input, idle high
// - start_i        : 1-cycle pulse, arm a new load
// - mem            : memory write port (master)
// - proc_hold_o    : 1 = keep processor in reset
// - load_done_o    : 1 = all samples stored
// - frame_err_o    : sticky stop-bit error
// - byte_count_o   : bytes stored in the current load
module uart_sample_loader
    import audio_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NUM_SAMPLES = 4096
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              uart_rx_i,
    input  logic              start_i,
    uart_sample_loader_if.master mem,
    output logic              proc_hold_o,
    output logic              load_done_o,
    output logic              frame_err_o,
    output logic [ADDR_W-1:0] byte_count_o
);

    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] BaseW = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] NumW  = ADDR_W'(NUM_SAMPLES);
    localparam logic [ADDR_W-1:0] LastW = ADDR_W'(NUM_SAMPLES - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       stop_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rx_i       (uart_rx_i),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte),
        .stop_err_o (stop_err)
    );

    ld_state_t         state_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              we_q;
    logic              hold_q;
    logic              done_q;
    logic              ferr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= L_WAIT;
            count_q <= '0;
            addr_q  <= BaseW;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                L_WAIT: begin
                    if (start_i) begin
                        state_q <= L_LOAD;
                        count_q <= '0;
                        ferr_q  <= 1'b0;
                    end
                end
                L_LOAD: begin
                    // Start is ignored here; only valid bytes advance the load.
                    if (rx_valid && (count_q < NumW)) begin
                        we_q    <= 1'b1;
                        addr_q  <= BaseW + count_q;
                        wdata_q <= rx_byte;
                        count_q <= count_q + 1'b1;
                        if (count_q == LastW) begin
                            state_q <= L_DONE;
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                L_DONE: begin
                    if (start_i) begin
                        state_q <= L_LOAD;
                        count_q <= '0;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                default: state_q <= L_WAIT;
            endcase
            // A framing error in the same cycle as an accepted start still sticks.
            if (stop_err) begin
                ferr_q <= 1'b1;
            end
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign proc_hold_o   = hold_q;
    assign load_done_o   = done_q;
    assign frame_err_o   = ferr_q;
    assign byte_count_o  = count_q;

endmodule
